// File: rtl/simon_pkg.sv
// Shared Simon-game types and constants used by the blinker and its neighbours.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam int NUM_COLOURS = 4;
    localparam int LEVEL_W     = 4;
    localparam int MAX_LEVEL   = 10;

    // Colour index to LED lane; colour 0 drives bit 0.
    function automatic logic [NUM_COLOURS-1:0] colourOneHot(input colour_t c);
        logic [NUM_COLOURS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational from the count.
module blink_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/sequence_blinker.sv
// Plays back the first `level` colours of the sequence memory on one-hot LEDs,
// each lit for ON_CYCLES then dark for OFF_CYCLES, and flags completion.
module sequence_blinker
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   on_blinker,
    input  logic [LEVEL_W-1:0]     level,
    input  colour_t                mem_data,
    output logic [LEVEL_W-1:0]     mem_addr,
    output logic [NUM_COLOURS-1:0] led,
    output logic                   blinker_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ON,
        OFF,
        DONE
    } blinker_state_t;

    localparam logic [15:0] ON_LOAD  = 16'(ON_CYCLES - 1);
    localparam logic [15:0] OFF_LOAD = 16'(OFF_CYCLES - 1);

    blinker_state_t         r_state;
    logic [LEVEL_W-1:0]     r_idx;
    logic [LEVEL_W-1:0]     r_levelQ;
    colour_t                r_colourQ;
    logic [NUM_COLOURS-1:0] r_led;
    logic                   r_done;

    blinker_state_t w_nextState;
    logic           w_timerLoad;
    logic [15:0]    w_loadValue;
    logic           w_timerEn;
    logic           w_timerZero;
    logic           w_lastElem;

    blink_timer #(.WIDTH(16)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_timerLoad),
        .load_value(w_loadValue),
        .en        (w_timerEn),
        .zero      (w_timerZero)
    );

    // Widened compare so level 15 ends cleanly without idx wrapping.
    assign w_lastElem   = ({1'b0, r_idx} + 5'd1) == {1'b0, r_levelQ};
    assign mem_addr     = r_idx;
    assign led          = r_led;
    assign blinker_done = r_done;

    always_comb begin
        w_nextState = r_state;
        w_timerLoad = 1'b0;
        w_loadValue = ON_LOAD;
        w_timerEn   = 1'b0;
        case (r_state)
            IDLE: begin
                if (on_blinker) begin
                    w_nextState = (level == '0) ? DONE : FETCH;
                end
            end
            FETCH: w_nextState = LATCH;
            LATCH: begin
                w_timerLoad = 1'b1;
                w_loadValue = ON_LOAD;
                w_nextState = ON;
            end
            ON: begin
                if (w_timerZero) begin
                    w_timerLoad = 1'b1;
                    w_loadValue = OFF_LOAD;
                    w_nextState = OFF;
                end else begin
                    w_timerEn = 1'b1;
                end
            end
            OFF: begin
                if (w_timerZero) begin
                    w_nextState = w_lastElem ? DONE : FETCH;
                end else begin
                    w_timerEn = 1'b1;
                end
            end
            DONE:    w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
        // Losing the enable aborts playback from any active state.
        if ((r_state != IDLE) && !on_blinker) begin
            w_nextState = IDLE;
        end
    end

    // LED lights on the LATCH->ON edge straight from memory, since colour_q loads on that same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_levelQ  <= '0;
            r_colourQ <= '0;
            r_led     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= (w_nextState == DONE);
            r_led   <= '0;
            if (w_nextState == ON) begin
                r_led <= (r_state == LATCH) ? colourOneHot(mem_data) : colourOneHot(r_colourQ);
            end
            if ((r_state == IDLE) && on_blinker) begin
                r_levelQ <= level;
            end
            if (r_state == LATCH) begin
                r_colourQ <= mem_data;
            end
            if (w_nextState == IDLE) begin
                r_idx <= '0;
            end else if ((r_state == OFF) && w_timerZero) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sequence_blinker.sv
// Randomized bench for sequence_blinker against a cycle-offset reference model.
module tb_sequence_blinker;

    localparam int ON_C  = 4;
    localparam int OFF_C = 2;
    localparam int PER   = 2 + ON_C + OFF_C;

    logic       clk;
    logic       reset;
    logic       onBlinker;
    logic [3:0] level;
    logic [1:0] memData;
    logic [3:0] memAddr;
    logic [3:0] led;
    logic       blinkerDone;

    logic [1:0] mem [16];

    int testsRun;
    int failCount;

    sequence_blinker #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
        .clk         (clk),
        .reset       (reset),
        .on_blinker  (onBlinker),
        .level       (level),
        .mem_data    (memData),
        .mem_addr    (memAddr),
        .led         (led),
        .blinker_done(blinkerDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence memory with one cycle of read latency.
    always @(posedge clk) memData <= mem[memAddr];

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Expected outputs k edges after the start edge e0, from the playback timing rules.
    task automatic modelAt(input int lvl, input int k, output logic [3:0] eLed,
                           output logic eDone, output logic [3:0] eAddr);
        int n;
        int ph;
        eLed  = 4'd0;
        eDone = 1'b0;
        eAddr = 4'd0;
        n  = k / PER;
        ph = k % PER;
        if (lvl == 0) begin
            eDone = 1'b1;
        end else if (n >= lvl) begin
            eDone = 1'b1;
            eAddr = 4'(lvl);
        end else begin
            eAddr = 4'(n);
            if (ph >= 2 && ph < 2 + ON_C) eLed = 4'(1 << mem[n]);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " led"},  16'(led), 16'd0);
        checkOutput({tag, " done"}, 16'(blinkerDone), 16'd0);
        checkOutput({tag, " addr"}, 16'(memAddr), 16'd0);
    endtask

    // One playback from IDLE; dropAt/resetAt give the k at which to abort, -1 for none.
    task automatic applyStimulus(input string name, input int lvl, input int dropAt, input int resetAt);
        int total;
        logic [3:0] eLed;
        logic       eDone;
        logic [3:0] eAddr;
        total     = (lvl == 0) ? 0 : lvl * PER;
        onBlinker = 1'b1;
        level     = 4'(lvl);
        @(posedge clk); #1;
        for (int k = 0; k <= total + 3; k++) begin
            modelAt(lvl, k, eLed, eDone, eAddr);
            checkOutput($sformatf("%s k=%0d led", name, k),  16'(led), 16'(eLed));
            checkOutput($sformatf("%s k=%0d done", name, k), 16'(blinkerDone), 16'(eDone));
            checkOutput($sformatf("%s k=%0d addr", name, k), 16'(memAddr), 16'(eAddr));
            if (k == dropAt || k == resetAt || k == total + 3) break;
            level = (k == 2) ? 4'd7 : 4'($urandom_range(15, 0));
            @(posedge clk); #1;
        end
        if (resetAt >= 0) begin
            reset     = 1'b0;
            onBlinker = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            checkIdle({name, " after reset"});
        end else begin
            onBlinker = 1'b0;
            @(posedge clk); #1;
            checkIdle({name, " after drop"});
        end
        @(posedge clk); #1;
        checkIdle({name, " idle hold"});
    endtask

    initial begin
        int lvl;
        int drop;
        testsRun  = 0;
        failCount = 0;
        reset     = 1'b0;
        onBlinker = 1'b1;
        level     = 4'd5;
        for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        onBlinker = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        checkIdle("post reset");

        mem[0] = 2'd2;
        mem[1] = 2'd0;
        applyStimulus("two elems", 2, -1, -1);
        applyStimulus("level zero", 0, -1, -1);
        applyStimulus("drop in on", 3, PER + 3, -1);
        applyStimulus("restart", 3, -1, -1);
        applyStimulus("reset in off", 5, -1, PER + 6);

        for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
        applyStimulus("level 15", 15, -1, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(3, 0));
            lvl  = $urandom_range(15, 0);
            drop = ($urandom_range(1, 0) == 1) ? $urandom_range(lvl * PER + 2, 1) : -1;
            applyStimulus($sformatf("rand%0d", r), lvl, drop, -1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/sequence_blinker.md
SEQUENCE_BLINKER -- requirements
Module: sequence_blinker

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 4, LED-lit cycles per sequence element (legal range 1..2^16-1).
REQ-002 SHALL have parameter OFF_CYCLES, default 2, dark-gap cycles after each element (legal range 1..2^16-1).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 on_blinker  input  1  enable from game FSM; high for the whole playback.
REQ-006 level  input  4  number of sequence elements to play (0..15).
REQ-007 mem_data  input  2  colour index read from sequence memory; valid one cycle after mem_addr.
REQ-008 mem_addr  output  4  sequence memory read address (element index).
REQ-009 led  output  4  one-hot colour LEDs; 4'b0000 = dark.
REQ-010 blinker_done  output  1  playback complete; held high until on_blinker drops.

Function
REQ-011 States SHALL be IDLE, FETCH, LATCH, ON, OFF and DONE.
REQ-012 IDLE: led=0, blinker_done=0, idx=0; on_blinker sampled high at edge e0 latches level into level_q; go FETCH, or DONE if level==0.
REQ-013 mem_addr SHALL equal idx combinationally in every state; idx is 4 bits.
REQ-014 FETCH SHALL last exactly 1 cycle, then go LATCH.
REQ-015 LATCH SHALL capture mem_data into colour_q, load timer with ON_CYCLES-1 and go ON.
REQ-016 ON: led registered = one-hot(colour_q) (0->0001, 1->0010, 2->0100, 3->1000); timer decrements; at timer==0 load OFF_CYCLES-1 and go OFF.
REQ-017 OFF: led=0; at timer==0 increment idx; go DONE if idx+1==level_q, else FETCH.
REQ-018 Per element cost SHALL be exactly 2+ON_CYCLES+OFF_CYCLES cycles; led first non-zero at e2; blinker_done rises at e0+level*(2+ON_CYCLES+OFF_CYCLES).
REQ-019 DONE: blinker_done=1, led=0; stay while on_blinker high; go IDLE on the cycle after on_blinker is sampled low.
REQ-020 on_blinker sampled low in any state other than IDLE SHALL abort to IDLE at that edge; led and blinker_done are 0 from that edge.
REQ-021 level changes after e0 SHALL be ignored until the next IDLE exit.
REQ-022 Timer width SHALL be 16 bits; timer SHALL never wrap below 0.
REQ-023 idx reaching 15 with level_q==15 SHALL terminate normally in DONE, with no wrap to 0 before DONE.

Reset
REQ-024 reset==0 at a rising edge SHALL force IDLE, idx=0, timer=0, colour_q=0, level_q=0, led=0, blinker_done=0, overriding all other inputs, including mid-playback.
REQ-025 First playback after reset release SHALL start only on on_blinker sampled high in IDLE.

Structure
REQ-026 Shared package simon_pkg SHALL hold the colour_t typedef (2-bit), the NUM_COLOURS=4 constant, the LEVEL_W=4 constant and the MAX_LEVEL=10 constant.
REQ-027 Package state enum blinker_state_t SHALL be local to this module.
REQ-028 The down-counter SHALL be a sub-module blink_timer (load, load_value, en, zero flag).
REQ-029 The implementation SHALL use a single sequential process for state, idx and led, plus combinational next-state logic.

Verification (ON_CYCLES=4, OFF_CYCLES=2, memory model with 1-cycle read latency)
REQ-030 Scenario: memory {2,0}, level=2, on_blinker held high -> led 0100 for 4 cycles from e2, dark 2 cycles, led 0001 for 4 cycles from e10; blinker_done rises at e16.
REQ-031 Scenario: level=0 -> blinker_done=1 at e0, led never non-zero, mem_addr stays 0.
REQ-032 Scenario: on_blinker dropped during ON of element 1, level=3 -> IDLE at next edge, led=0, blinker_done never asserted; re-raising on_blinker restarts at mem_addr=0.
REQ-033 Scenario: reset pulsed low for 1 cycle during OFF with level=5 -> all outputs 0 at the following edge, state IDLE, idx=0.
REQ-034 Scenario: level=15 with memory 0..3 repeating -> 15 blinks in colour order, mem_addr sequence 0..14, blinker_done at e0+120, drop on_blinker -> IDLE next edge.
REQ-035 Scenario: level changed from 2 to 7 at e3 -> exactly 2 elements played; blinker_done at e16.
